edu_cosim_wrapper: RTL and testbench
====================================

EDU_COSIM_WRAPPER -- requirements
Module: edu_cosim_wrapper

Interface
REQ-001 Parameter W, default 11: data width in bits, i.e. the number of dual-rail digits per channel.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop depth of every input synchronizer.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 datain_d  input  2*W  input channel rails; bit 2i = rail 0 of digit i, bit 2i+1 = rail 1 of digit i.
REQ-006 datain_e  output  1  input channel enable; 1 = ready for a new token, 0 = token accepted.
REQ-007 dataout_d  output  2*W  output channel rails, same encoding as datain_d.
REQ-008 dataout_e  input  1  output channel enable driven by the consumer.
REQ-009 err  output  1  sticky illegal-codeword flag.

Function
REQ-010 The block SHALL treat datain_d, datain_e and dataout_e as asynchronous and pass each through a SYNC_STAGES synchronizer before use.
REQ-011 Digit i SHALL be valid when exactly one of its two rails is 1, and neutral when both rails are 0.
REQ-012 The input word SHALL be complete when all W digits are valid, and neutral when all W digits are neutral.
REQ-013 The block SHALL hold an accumulator ACC of W bits.
REQ-014 On each accepted token A, ACC SHALL become (ACC + A) mod 2^W; overflow wraps silently and no carry is kept.
REQ-015 The block SHALL use a four-state FSM: WAIT_IN, IN_RTZ, OUT_SEND, OUT_RTZ.
REQ-016 WAIT_IN: datain_e = 1 and dataout_d = neutral; when the synced input is complete, capture A, update ACC, and go to IN_RTZ.
REQ-017 IN_RTZ: datain_e = 0; when the synced input is neutral, go to OUT_SEND.
REQ-018 OUT_SEND: when synced dataout_e = 1, drive dataout_d with the dual-rail code of ACC from a register, and hold it until synced dataout_e = 0, then go to OUT_RTZ.
REQ-019 OUT_RTZ: dataout_d = neutral; when synced dataout_e = 1, go to WAIT_IN.
REQ-020 dataout_d SHALL never change from one valid codeword directly to another; a neutral word always lies between tokens.
REQ-021 All rail outputs SHALL come straight from flip-flops, with no combinational glitches.
REQ-022 Handling of a token is strictly sequential; a new input token is not accepted until the previous sum has completed output return-to-zero.
REQ-023 A partially valid input word (some digits valid, some neutral) SHALL be ignored until it becomes complete.
REQ-024 Latency: the output codeword SHALL appear no later than SYNC_STAGES+3 cycles after the input becomes neutral, provided dataout_e = 1.
REQ-025 If dataout_e is already 0 on entry to OUT_SEND, the block SHALL wait in OUT_SEND with dataout_d neutral until dataout_e rises.

Reset
REQ-026 While RESET = 1, the FSM SHALL be in WAIT_IN, with ACC = 0, err = 0, dataout_d = all 0, datain_e = 0, and all synchronizer flops = 0.
REQ-027 On the first CLK edge after RESET falls, datain_e SHALL become 1.
REQ-028 Reset asserted mid-handshake SHALL abort the transfer immediately; no partial codeword is left on dataout_d.

Configuration
REQ-029 The macro EDU_ERR_CHECK_EN, when defined, SHALL make err go to 1 and stay set until reset whenever any synced input digit has both rails = 1.
REQ-030 With EDU_ERR_CHECK_EN defined, an input word containing an illegal digit SHALL NOT be treated as complete.
REQ-031 With EDU_ERR_CHECK_EN undefined, err SHALL be tied to 0, and a digit with both rails = 1 SHALL be decoded as value 1.

Verification
REQ-032 Reset for 400 ns, then tokens 1, 2, 3, 4 -> outputs 1, 3, 6, 10, each followed by a neutral word.
REQ-033 ACC = 2040, then token 10 -> output 2 (wrap mod 2048).
REQ-034 Consumer holds dataout_e = 0 for 50 cycles -> dataout_d stays neutral and datain_e stays 0 until dataout_e rises.
REQ-035 Input digits arrive skewed one per cycle over 11 cycles -> exactly one accept, and the sum is correct.
REQ-036 With EDU_ERR_CHECK_EN defined, digit 3 driven with both rails = 1 -> err = 1, no output token, and ACC unchanged.
REQ-037 RESET pulsed during OUT_SEND -> dataout_d = 0, ACC = 0, and the next token 5 outputs 5.

Source files
------------

// File: rtl/edu_cosim_wrapper.sv
// edu_cosim_wrapper
//    Dual-rail (four-phase, return-to-zero) accumulator wrapper. Each complete
//    input token is added into a W-bit accumulator modulo 2^W, and the new sum
//    is returned as a dual-rail token on the output channel.
//
// Ports
//    CLK        sole clock, rising edge
//    RESET      asynchronous, active-high reset
//    datain_d   input rails, bit 2i = rail 0 / bit 2i+1 = rail 1 of digit i
//    datain_e   input enable: 1 = ready for a token, 0 = token accepted
//    dataout_d  output rails, same encoding, driven from flops
//    dataout_e  output enable from the consumer
//    err        sticky illegal-codeword flag
//
// Configuration
//    EDU_ERR_CHECK_EN  when defined, a synced digit with both rails high sets
//                      err (sticky until reset) and keeps the word incomplete.
//                      When undefined, err is tied low and such a digit
//                      decodes as value 1.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// WAIT_IN  | ready for input, output neutral; capture on complete word
// IN_RTZ   | token accepted, waiting for input to return to neutral
// OUT_SEND | present sum once consumer enable is high, hold until it drops
// OUT_RTZ  | output neutral, waiting for consumer enable to rise again
module edu_cosim_wrapper #(
   parameter int W           = 11,
   parameter int SYNC_STAGES = 2
) (
   input  logic           CLK,
   input  logic           RESET,
   input  logic [2*W-1:0] datain_d,
   output logic           datain_e,
   output logic [2*W-1:0] dataout_d,
   input  logic           dataout_e,
   output logic           err
);

   typedef enum logic [1:0] {WAIT_IN, IN_RTZ, OUT_SEND, OUT_RTZ} state_t;

   state_t         state;
   logic [W-1:0]   acc;
   logic           sent;

   logic [2*W-1:0] din_sync [SYNC_STAGES];
   logic [SYNC_STAGES-1:0] de_sync;
   logic [2*W-1:0] din_s;
   logic           de_s;

   logic [W-1:0]   din_val;
   logic           complete;
   logic           neutral;
`ifdef EDU_ERR_CHECK_EN
   logic           illegal;
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int s = 0; s < SYNC_STAGES; s++) din_sync[s] <= '0;
         de_sync <= '0;
      end else begin
         din_sync[0] <= datain_d;
         de_sync[0]  <= dataout_e;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            din_sync[s] <= din_sync[s-1];
            de_sync[s]  <= de_sync[s-1];
         end
      end
   end

   assign din_s = din_sync[SYNC_STAGES-1];
   assign de_s  = de_sync[SYNC_STAGES-1];

   // Rail 1 carries the bit value; a partial word never reports complete.
   always_comb begin
      din_val  = '0;
      complete = 1'b1;
`ifdef EDU_ERR_CHECK_EN
      illegal  = 1'b0;
`endif
      for (int i = 0; i < W; i++) begin
         din_val[i] = din_s[2*i+1];
`ifdef EDU_ERR_CHECK_EN
         if (!(din_s[2*i] ^ din_s[2*i+1])) complete = 1'b0;
         if (din_s[2*i] & din_s[2*i+1])    illegal  = 1'b1;
`else
         if (!(din_s[2*i] | din_s[2*i+1])) complete = 1'b0;
`endif
      end
   end

   assign neutral = ~|din_s;

   function automatic logic [2*W-1:0] dr_encode(input logic [W-1:0] v);
      logic [2*W-1:0] r;
      for (int i = 0; i < W; i++) begin
         r[2*i]   = ~v[i];
         r[2*i+1] = v[i];
      end
      return r;
   endfunction

   // Output rails only ever load all-zero or a full codeword, and a codeword
   // is only loaded from OUT_SEND after OUT_RTZ/WAIT_IN forced neutral.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= WAIT_IN;
         acc       <= '0;
         sent      <= 1'b0;
         datain_e  <= 1'b0;
         dataout_d <= '0;
      end else begin
         case (state)
            WAIT_IN: begin
               dataout_d <= '0;
               sent      <= 1'b0;
               if (complete) begin
                  acc      <= acc + din_val;
                  datain_e <= 1'b0;
                  state    <= IN_RTZ;
               end else begin
                  datain_e <= 1'b1;
               end
            end
            IN_RTZ: begin
               datain_e <= 1'b0;
               if (neutral) state <= OUT_SEND;
            end
            OUT_SEND: begin
               if (!sent) begin
                  if (de_s) begin
                     dataout_d <= dr_encode(acc);
                     sent      <= 1'b1;
                  end
               end else if (!de_s) begin
                  dataout_d <= '0;
                  sent      <= 1'b0;
                  state     <= OUT_RTZ;
               end
            end
            OUT_RTZ: begin
               dataout_d <= '0;
               if (de_s) begin
                  datain_e <= 1'b1;
                  state    <= WAIT_IN;
               end
            end
            default: state <= WAIT_IN;
         endcase
      end
   end

`ifdef EDU_ERR_CHECK_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)        err <= 1'b0;
      else if (illegal) err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_edu_cosim_wrapper.sv
// Directed bench for edu_cosim_wrapper: a table of tokens with hand-computed
// running sums, plus sequences for consumer stall, skewed digits, illegal
// digits and reset in the middle of a handshake.
module tb_edu_cosim_wrapper;
   localparam int W  = 11;
   localparam int SS = 2;

   logic           CLK = 1'b0;
   logic           RESET = 1'b1;
   logic [2*W-1:0] datain_d = '0;
   logic           datain_e;
   logic [2*W-1:0] dataout_d;
   logic           dataout_e = 1'b1;
   logic           err;

   int n_checks = 0;
   int n_pass   = 0;
   int accepts  = 0;
   int viol     = 0;
   logic [2*W-1:0] prev_out = '0;
   logic           prev_de  = 1'b0;

   typedef struct {
      logic [W-1:0] tok;
      logic [W-1:0] exp;
   } vec_t;
   vec_t vecs [8];

`ifdef EDU_ERR_CHECK_EN
   localparam int EXP_MID = 1475;
`else
   localparam int EXP_MID = 1486;
`endif

   always #5 CLK = ~CLK;

   edu_cosim_wrapper #(.W(W), .SYNC_STAGES(SS)) dut (
      .CLK(CLK), .RESET(RESET), .datain_d(datain_d), .datain_e(datain_e),
      .dataout_d(dataout_d), .dataout_e(dataout_e), .err(err)
   );

   function automatic logic [2*W-1:0] enc(input logic [W-1:0] v);
      logic [2*W-1:0] r;
      for (int i = 0; i < W; i++) begin
         r[2*i]   = ~v[i];
         r[2*i+1] = v[i];
      end
      return r;
   endfunction

   function automatic logic out_complete(input logic [2*W-1:0] d);
      for (int i = 0; i < W; i++) if (!(d[2*i] ^ d[2*i+1])) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [W-1:0] dec(input logic [2*W-1:0] d);
      logic [W-1:0] v;
      for (int i = 0; i < W; i++) v[i] = d[2*i+1];
      return v;
   endfunction

   // Accept counting and valid-to-valid output transitions, sampled after each edge.
   always @(posedge CLK) begin
      #1;
      if (RESET) begin
         prev_out = '0;
         prev_de  = 1'b0;
      end else begin
         if (prev_de && !datain_e) accepts++;
         if (dataout_d != '0 && prev_out != '0 && dataout_d != prev_out) viol++;
         prev_out = dataout_d;
         prev_de  = datain_e;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic wait_de(input logic val, input string name);
      int n = 0;
      while (datain_e !== val && n < 200) begin
         @(negedge CLK);
         n++;
      end
      check(name, {31'd0, datain_e}, {31'd0, val});
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_complete(dataout_d) && n < 200) begin
         @(negedge CLK);
         n++;
      end
   endtask

   // Token already on datain_d; completes the input and output handshakes.
   task automatic finish_handshake(input string name, input logic [W-1:0] exp,
                                   input int hold, input int acc0);
      int n;
      int bad;
      wait_de(1'b0, {name, " accept"});
      datain_d = '0;
      if (hold > 0) begin
         bad = 0;
         repeat (hold) begin
            @(negedge CLK);
            if (dataout_d !== '0 || datain_e !== 1'b0) bad++;
         end
         check({name, " stall neutral"}, bad, 0);
         dataout_e = 1'b1;
      end
      wait_out(n);
      check({name, " out valid"}, {31'd0, out_complete(dataout_d)}, 1);
      check({name, " out value"}, {21'd0, dec(dataout_d)}, {21'd0, exp});
      if (hold == 0) check({name, " latency ok"}, {31'd0, (n <= SS + 3)}, 1);
      check({name, " accept count"}, accepts - acc0, 1);
      dataout_e = 1'b0;
      n = 0;
      while (dataout_d !== '0 && n < 200) begin
         @(negedge CLK);
         n++;
      end
      check({name, " out rtz"}, dataout_d, 0);
      dataout_e = 1'b1;
      wait_de(1'b1, {name, " ready"});
   endtask

   initial begin
      int acc0;
      int bad;
      int n;
      logic [2*W-1:0] w;

      vecs[0] = '{tok: 11'd1,    exp: 11'd1};
      vecs[1] = '{tok: 11'd2,    exp: 11'd3};
      vecs[2] = '{tok: 11'd3,    exp: 11'd6};
      vecs[3] = '{tok: 11'd4,    exp: 11'd10};
      vecs[4] = '{tok: 11'd2030, exp: 11'd2040};
      vecs[5] = '{tok: 11'd10,   exp: 11'd2};
      vecs[6] = '{tok: 11'd2047, exp: 11'd1};
      vecs[7] = '{tok: 11'd0,    exp: 11'd1};

      #200;
      check("reset datain_e", {31'd0, datain_e}, 0);
      check("reset dataout_d", dataout_d, 0);
      check("reset err", {31'd0, err}, 0);
      #200;
      RESET = 1'b0;
      #1;
      check("post-reset before edge datain_e", {31'd0, datain_e}, 0);
      @(posedge CLK);
      #1;
      check("first edge datain_e", {31'd0, datain_e}, 1);
      @(negedge CLK);

      for (int i = 0; i < 8; i++) begin
         acc0 = accepts;
         datain_d = enc(vecs[i].tok);
         finish_handshake($sformatf("vec%0d", i), vecs[i].exp, 0, acc0);
      end

      // consumer stalls 50 cycles: 1 + 100
      acc0 = accepts;
      dataout_e = 1'b0;
      datain_d = enc(11'd100);
      finish_handshake("stall", 11'd101, 50, acc0);

      // digits of 0x555 arrive one per cycle: 101 + 1365
      acc0 = accepts;
      bad = 0;
      w = enc(11'h555);
      datain_d = '0;
      for (int i = 0; i < W; i++) begin
         datain_d[2*i +: 2] = w[2*i +: 2];
         @(negedge CLK);
         if (i < W - 1 && datain_e !== 1'b1) bad++;
      end
      check("skew partial ignored", bad, 0);
      finish_handshake("skew", 11'd1466, 0, acc0);

`ifdef EDU_ERR_CHECK_EN
      acc0 = accepts;
      w = enc(11'd0);
      w[7:6] = 2'b11;
      datain_d = w;
      repeat (10) @(negedge CLK);
      check("illegal err set", {31'd0, err}, 1);
      check("illegal not accepted", {31'd0, datain_e}, 1);
      check("illegal no output", dataout_d, 0);
      check("illegal accept count", accepts - acc0, 0);
      datain_d = '0;
      repeat (5) @(negedge CLK);
      acc0 = accepts;
      datain_d = enc(11'd2);
      finish_handshake("post illegal", 11'd1468, 0, acc0);
      check("err sticky", {31'd0, err}, 1);
`else
      // digit 3 both rails decodes as 1: 5 | 8 = 13, 1466 + 13
      acc0 = accepts;
      w = enc(11'd5);
      w[7:6] = 2'b11;
      datain_d = w;
      finish_handshake("both rails", 11'd1479, 0, acc0);
      check("err tied low", {31'd0, err}, 0);
`endif

      // reset while the sum is presented in OUT_SEND
      datain_d = enc(11'd7);
      wait_de(1'b0, "mid accept");
      datain_d = '0;
      wait_out(n);
      check("mid out value", {21'd0, dec(dataout_d)}, EXP_MID);
      RESET = 1'b1;
      #1;
      check("mid reset dataout_d", dataout_d, 0);
      check("mid reset datain_e", {31'd0, datain_e}, 0);
      check("mid reset err", {31'd0, err}, 0);
      @(negedge CLK);
      RESET = 1'b0;
      wait_de(1'b1, "mid reset ready");
      acc0 = accepts;
      datain_d = enc(11'd5);
      finish_handshake("after reset", 11'd5, 0, acc0);

      check("no valid-to-valid output", viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
